// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the I-cache, D-cache and physical-memory signals that
//             meet at the memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  // I-cache side
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // D-cache side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // Physical memory side
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  // Status
  logic              timeout_err;

  // Arbiter view
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr,
           pmem_wdata, timeout_err
  );

  // Environment view (caches plus memory)
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr,
           pmem_wdata, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one line-granular memory port between the I-cache and
//             D-cache. One transaction at a time, round-robin on ties, with a
//             sticky watchdog flag for a memory that never answers.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,   // asynchronous, active low
  mem_arbiter_if.slave  bus
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: D side won the last grant
  logic              cmd_rd_q, cmd_rd_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic i_pend;
  logic d_pend;
  logic grant_i;
  logic grant_d;
  logic serving;

  assign i_pend  = bus.i_read;
  assign d_pend  = bus.d_read | bus.d_write;
  // On a tie the side that did not win last time gets the port.
  assign grant_d = d_pend & (~i_pend | ~last_d_q);
  assign grant_i = i_pend & ~grant_d;
  assign serving = (state_q != IDLE);

  // Next state, grant bookkeeping and command capture at grant time
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cmd_rd_d = cmd_rd_q;
    cmd_wr_d = cmd_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          // A simultaneous read+write is illegal; the writeback wins.
          cmd_wr_d = bus.d_write;
          cmd_rd_d = bus.d_read & ~bus.d_write;
          addr_d   = bus.d_addr;
          wdata_d  = bus.d_wdata;
        end else if (grant_i) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          cmd_wr_d = 1'b0;
          cmd_rd_d = 1'b1;
          addr_d   = bus.i_addr;
          wdata_d  = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        // The captured command is held until memory answers; dropping the
        // request mid-transaction does not abort it.
        if (bus.pmem_resp) begin
          state_d  = IDLE;
          cmd_rd_d = 1'b0;
          cmd_wr_d = 1'b0;
          addr_d   = '0;
          wdata_d  = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        cmd_rd_d = 1'b0;
        cmd_wr_d = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
      end
    endcase
  end

  // State and captured command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cmd_rd_q <= 1'b0;
      cmd_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cmd_rd_q <= cmd_rd_d;
      cmd_wr_q <= cmd_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Command registers are zero outside SERVE, so IDLE never drives memory.
  assign bus.pmem_read  = cmd_rd_q;
  assign bus.pmem_write = cmd_wr_q;
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;

  // Completion is steered only to the side being served; data is shared.
  assign bus.i_resp  = (state_q == SERVE_I) & bus.pmem_resp;
  assign bus.d_resp  = (state_q == SERVE_D) & bus.pmem_resp;
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;

  generate
    if (TIMEOUT > 0) begin : g_wd
      logic [WD_W-1:0] wd_q, wd_d;
      logic            err_q, err_d;

      // Count SERVE cycles without a response; flag once the limit is hit
      always_comb begin
        wd_d  = wd_q;
        err_d = err_q;
        if (!serving) begin
          wd_d = '0;
        end else if (!bus.pmem_resp && (wd_q != WD_MAX)) begin
          wd_d = wd_q + 1'b1;
        end
        if (serving && (wd_d == WD_MAX)) begin
          err_d = 1'b1;
        end
      end

      // Watchdog counter and sticky error flag
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wd_q  <= '0;
          err_q <= 1'b0;
        end else begin
          wd_q  <= wd_d;
          err_q <= err_d;
        end
      end

      assign bus.timeout_err = err_q;
    end else begin : g_no_wd
      assign bus.timeout_err = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter: vector table of request
//             scenarios with a per-side scoreboard, plus hand-written
//             reset, stray-response and watchdog sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int LINE_W  = 256;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int                n_i;
    int                n_d;
    logic [ADDR_W-1:0] i_addr;
    logic [ADDR_W-1:0] d_addr;
    logic              d_rd;
    logic              d_wr;
    int                lat;
    logic              chg;
    logic              exp_first_d;
  } vec_t;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } exp_t;

  exp_t sb_i[$];
  exp_t sb_d[$];
  vec_t vt[8];
  int   n_pass  = 0;
  int   n_total = 0;
  logic model_last_d = 1'b0;

  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {8{a}} ^ {32{8'hA5}};
  endfunction

  function automatic logic [LINE_W-1:0] wdat_of(input logic [ADDR_W-1:0] a);
    return ~{8{a}};
  endfunction

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive_i(input logic [ADDR_W-1:0] a);
    exp_t e;
    bus.i_read = 1'b1;
    bus.i_addr = a;
    e.wr = 1'b0; e.addr = a; e.wdata = '0;
    sb_i.push_back(e);
  endtask

  task automatic drive_d(input logic [ADDR_W-1:0] a, input logic rd, input logic wr);
    exp_t e;
    bus.d_read  = rd;
    bus.d_write = wr;
    bus.d_addr  = a;
    bus.d_wdata = wdat_of(a);
    e.wr = wr; e.addr = a; e.wdata = wdat_of(a);
    sb_d.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_pmem_read"},  LINE_W'(bus.pmem_read),  '0);
    chk({tag, "_pmem_write"}, LINE_W'(bus.pmem_write), '0);
    chk({tag, "_pmem_addr"},  LINE_W'(bus.pmem_addr),  '0);
    chk({tag, "_pmem_wdata"}, bus.pmem_wdata,          '0);
    chk({tag, "_i_resp"},     LINE_W'(bus.i_resp),     '0);
    chk({tag, "_d_resp"},     LINE_W'(bus.d_resp),     '0);
    chk({tag, "_timeout"},    LINE_W'(bus.timeout_err),'0);
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int   i_rem, d_rem, gap, ncmd, mem_cnt, cyc;
    logic cmd, cmd_prev, cur_d, side_d;
    exp_t cur;
    i_rem = v.n_i; d_rem = v.n_d; gap = 0; ncmd = 0; mem_cnt = 0; cyc = 0;
    cmd_prev = 1'b0; cur_d = 1'b0;
    cur.wr = 1'b0; cur.addr = '0; cur.wdata = '0;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    if (i_rem > 0) drive_i(v.i_addr);
    if (d_rem > 0) drive_d(v.d_addr, v.d_rd, v.d_wr);
    while ((i_rem > 0 || d_rem > 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      cmd = bus.pmem_read | bus.pmem_write;
      // Memory model: answer in the v.lat-th cycle of each command.
      if (cmd) begin
        mem_cnt++;
        bus.pmem_resp  = (mem_cnt == v.lat);
        bus.pmem_rdata = line_of(bus.pmem_addr);
      end else begin
        mem_cnt = 0;
        bus.pmem_resp = 1'b0;
      end
      #1;
      if (cmd && !cmd_prev) begin
        if (ncmd == 0) side_d = v.exp_first_d;
        else if (bus.i_read && (bus.d_read || bus.d_write)) side_d = !model_last_d;
        else side_d = (bus.d_read || bus.d_write);
        if (side_d ? (sb_d.size() == 0) : (sb_i.size() == 0)) begin
          chk($sformatf("v%0d_grant_has_request", idx), '0, LINE_W'(1));
          cur.wr = 1'b0; cur.addr = '1; cur.wdata = '1;
        end else begin
          cur = side_d ? sb_d[0] : sb_i[0];
        end
        if (ncmd > 0) chk($sformatf("v%0d_idle_gap", idx), LINE_W'(gap), LINE_W'(1));
        cur_d = side_d;
        model_last_d = side_d;
        ncmd++;
        gap = 0;
        if (v.chg) begin
          if (side_d) begin
            bus.d_addr  = bus.d_addr ^ 32'h100;
            bus.d_wdata = ~bus.d_wdata;
          end else begin
            bus.i_addr = bus.i_addr ^ 32'h100;
          end
        end
      end
      if (cmd) begin
        chk($sformatf("v%0d_pmem_addr", idx),  LINE_W'(bus.pmem_addr),  LINE_W'(cur.addr));
        chk($sformatf("v%0d_pmem_write", idx), LINE_W'(bus.pmem_write), LINE_W'(cur.wr));
        chk($sformatf("v%0d_pmem_read", idx),  LINE_W'(bus.pmem_read),  LINE_W'(!cur.wr));
        chk($sformatf("v%0d_pmem_wdata", idx), bus.pmem_wdata,          cur.wdata);
      end else begin
        gap++;
      end
      if (cmd && bus.pmem_resp) begin
        chk($sformatf("v%0d_i_resp", idx), LINE_W'(bus.i_resp), LINE_W'(!cur_d));
        chk($sformatf("v%0d_d_resp", idx), LINE_W'(bus.d_resp), LINE_W'(cur_d));
        chk($sformatf("v%0d_rdata", idx), cur_d ? bus.d_rdata : bus.i_rdata, line_of(cur.addr));
        if (cur_d) begin
          if (sb_d.size() > 0) void'(sb_d.pop_front());
          d_rem--;
          if (d_rem > 0) drive_d(cur.addr + 32'h20, v.d_rd, v.d_wr);
          else begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
        end else begin
          if (sb_i.size() > 0) void'(sb_i.pop_front());
          i_rem--;
          if (i_rem > 0) drive_i(cur.addr + 32'h20);
          else bus.i_read = 1'b0;
        end
      end else begin
        chk($sformatf("v%0d_no_resp", idx), LINE_W'({bus.i_resp, bus.d_resp}), '0);
      end
      cmd_prev = cmd;
    end
    if (i_rem > 0 || d_rem > 0) chk($sformatf("v%0d_completed", idx), '0, LINE_W'(1));
  endtask

  initial begin
    int sc;
    vt[0] = '{n_i:1, n_d:0, i_addr:32'h0000_1000, d_addr:32'h0,   d_rd:1'b0, d_wr:1'b0, lat:3, chg:1'b0, exp_first_d:1'b0};
    vt[1] = '{n_i:1, n_d:1, i_addr:32'h100,  d_addr:32'h200, d_rd:1'b0, d_wr:1'b1, lat:2, chg:1'b0, exp_first_d:1'b1};
    vt[2] = '{n_i:2, n_d:2, i_addr:32'h800,  d_addr:32'h900, d_rd:1'b1, d_wr:1'b0, lat:1, chg:1'b0, exp_first_d:1'b1};
    vt[3] = '{n_i:0, n_d:1, i_addr:32'h0,    d_addr:32'h300, d_rd:1'b1, d_wr:1'b1, lat:2, chg:1'b0, exp_first_d:1'b1};
    vt[4] = '{n_i:1, n_d:0, i_addr:32'h400,  d_addr:32'h0,   d_rd:1'b0, d_wr:1'b0, lat:4, chg:1'b1, exp_first_d:1'b0};
    vt[5] = '{n_i:0, n_d:3, i_addr:32'h0,    d_addr:32'h600, d_rd:1'b1, d_wr:1'b0, lat:1, chg:1'b0, exp_first_d:1'b1};
    vt[6] = '{n_i:1, n_d:1, i_addr:32'hA00,  d_addr:32'hB00, d_rd:1'b0, d_wr:1'b1, lat:5, chg:1'b1, exp_first_d:1'b0};
    vt[7] = '{n_i:1, n_d:1, i_addr:32'hC00,  d_addr:32'hD00, d_rd:1'b1, d_wr:1'b0, lat:2, chg:1'b0, exp_first_d:1'b1};

    rst = 1'b0;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b1;

    // Reset state, with a stray memory response and a pending request present
    bus.i_read = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    bus.i_read = 1'b0;
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 7; k++) run_vector(k, vt[k]);

    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    chk("no_early_timeout", LINE_W'(bus.timeout_err), '0);

    // Memory response while idle must be ignored
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    chk("idle_resp_i", LINE_W'(bus.i_resp), '0);
    chk("idle_resp_d", LINE_W'(bus.d_resp), '0);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    chk("idle_resp_no_cmd", LINE_W'({bus.pmem_read, bus.pmem_write}), '0);

    // Watchdog: memory never answers
    bus.i_read = 1'b1;
    bus.i_addr = 32'h700;
    sc = 0;
    for (int k = 0; k < 30 && sc < 12; k++) begin
      @(negedge clk);
      #1;
      if (bus.pmem_read) sc++;
      if (sc == 8 && bus.pmem_read) chk("wd_not_yet", LINE_W'(bus.timeout_err), '0);
      if (sc == 9 && bus.pmem_read) chk("wd_set", LINE_W'(bus.timeout_err), LINE_W'(1));
    end
    chk("wd_serve_cycles", LINE_W'(sc), LINE_W'(12));
    chk("wd_sticky", LINE_W'(bus.timeout_err), LINE_W'(1));
    chk("wd_still_waiting", LINE_W'(bus.pmem_read), LINE_W'(1));
    chk("wd_addr_held", LINE_W'(bus.pmem_addr), LINE_W'(32'h700));

    // Asynchronous reset in mid-cycle
    #2;
    rst = 1'b0;
    bus.pmem_resp = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    bus.i_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.pmem_resp = 1'b0;
    model_last_d = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_idle", LINE_W'({bus.pmem_read, bus.pmem_write}), '0);

    // First tie after reset goes to D again
    run_vector(7, vt[7]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
